// File: rtl/rv_pkg.sv
// Shared RV32I constants for the decode/issue stage and the ALU it feeds.
package rv_pkg;
   localparam int XLEN = 32;

   typedef logic [3:0] alu_ctrl_t;
   localparam alu_ctrl_t ALU_ADD  = 4'd0;
   localparam alu_ctrl_t ALU_SUB  = 4'd1;
   localparam alu_ctrl_t ALU_AND  = 4'd2;
   localparam alu_ctrl_t ALU_OR   = 4'd3;
   localparam alu_ctrl_t ALU_XOR  = 4'd4;
   localparam alu_ctrl_t ALU_SLTU = 4'd5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SLTU = 3'b011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      alu_ctrl_t        alu_ctrl;
      logic [4:0]       rd;
      logic             reg_wr;
      logic [XLEN-1:0]  pc;
      logic             illegal;
   } id_ex_t;
endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of RV32I OP / OP-IMM into the ALU control code.
module alu_decoder
   import rv_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output alu_ctrl_t  alu_ctrl,
   output logic       illegal,
   output logic       use_imm
);
   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = 1'b1;
      use_imm  = 1'b0;
      case (opcode)
         OPC_OP: begin
            illegal = 1'b0;
            case (funct3)
               F3_ADD:  if (funct7 == F7_BASE) alu_ctrl = ALU_ADD;
                        else if (funct7 == F7_ALT) alu_ctrl = ALU_SUB;
                        else illegal = 1'b1;
               F3_AND:  if (funct7 == F7_BASE) alu_ctrl = ALU_AND;  else illegal = 1'b1;
               F3_OR:   if (funct7 == F7_BASE) alu_ctrl = ALU_OR;   else illegal = 1'b1;
               F3_XOR:  if (funct7 == F7_BASE) alu_ctrl = ALU_XOR;  else illegal = 1'b1;
               F3_SLTU: if (funct7 == F7_BASE) alu_ctrl = ALU_SLTU; else illegal = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            // funct7 is part of the immediate here, so it plays no role
            use_imm = 1'b1;
            illegal = 1'b0;
            case (funct3)
               F3_ADD:  alu_ctrl = ALU_ADD;
               F3_AND:  alu_ctrl = ALU_AND;
               F3_OR:   alu_ctrl = ALU_OR;
               F3_XOR:  alu_ctrl = ALU_XOR;
               F3_SLTU: alu_ctrl = ALU_SLTU;
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) alu_ctrl = ALU_ADD;
   end
endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: operand forwarding, immediate generation and the ID/EX register.
module id_ex_stage
   import rv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] rf_rs1_data,
   input  logic [XLEN-1:0] rf_rs2_data,
   input  logic            exmem_reg_wr,
   input  logic [4:0]      exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_reg_wr,
   input  logic [4:0]      memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   input  logic            stall,
   input  logic            flush,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_a,
   output logic [XLEN-1:0] ex_b,
   output logic [3:0]      ex_alu_ctrl,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_wr,
   output logic [XLEN-1:0] ex_pc,
   output logic            ex_illegal
);
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] fwd_a, fwd_b, imm;
   alu_ctrl_t       dec_ctrl;
   logic            dec_illegal, dec_use_imm;
   id_ex_t          q, nxt;

   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];
   assign rd  = in_instr[11:7];
   assign imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

   alu_decoder u_dec (
      .opcode   (in_instr[6:0]),
      .funct3   (in_instr[14:12]),
      .funct7   (in_instr[31:25]),
      .alu_ctrl (dec_ctrl),
      .illegal  (dec_illegal),
      .use_imm  (dec_use_imm)
   );

   // EX/MEM is younger than MEM/WB, so it wins when both target the same register
   always_comb begin
      fwd_a = rf_rs1_data;
      if (exmem_reg_wr && exmem_rd == rs1 && rs1 != 5'd0)      fwd_a = exmem_result;
      else if (memwb_reg_wr && memwb_rd == rs1 && rs1 != 5'd0) fwd_a = memwb_result;
      fwd_b = rf_rs2_data;
      if (exmem_reg_wr && exmem_rd == rs2 && rs2 != 5'd0)      fwd_b = exmem_result;
      else if (memwb_reg_wr && memwb_rd == rs2 && rs2 != 5'd0) fwd_b = memwb_result;
   end

   always_comb begin
      nxt          = '0;
      nxt.pc       = in_pc;
      if (in_valid) begin
         nxt.a        = fwd_a;
         nxt.b        = dec_use_imm ? imm : fwd_b;
         nxt.rd       = rd;
         nxt.illegal  = dec_illegal;
         nxt.valid    = !dec_illegal;
         nxt.alu_ctrl = dec_illegal ? ALU_ADD : dec_ctrl;
         nxt.reg_wr   = !dec_illegal && rd != 5'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q    <= '0;
         q.pc <= RESET_PC;
      end else if (flush) begin
         q    <= '0;
         q.pc <= q.pc;
      end else if (!stall) begin
         q    <= nxt;
      end
   end

   assign ex_valid    = q.valid;
   assign ex_a        = q.a;
   assign ex_b        = q.b;
   assign ex_alu_ctrl = q.alu_ctrl;
   assign ex_rd       = q.rd;
   assign ex_reg_wr   = q.reg_wr;
   assign ex_pc       = q.pc;
   assign ex_illegal  = q.illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors, expectations queued per edge.
module tb_id_ex_stage;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0, in_pc = '0, rf_rs1_data = '0, rf_rs2_data = '0;
   logic        exmem_reg_wr = 1'b0, memwb_reg_wr = 1'b0;
   logic [4:0]  exmem_rd = '0, memwb_rd = '0;
   logic [31:0] exmem_result = '0, memwb_result = '0;
   logic        stall = 1'b0, flush = 1'b0;
   logic        ex_valid, ex_reg_wr, ex_illegal;
   logic [31:0] ex_a, ex_b, ex_pc;
   logic [3:0]  ex_alu_ctrl;
   logic [4:0]  ex_rd;

   id_ex_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .exmem_reg_wr(exmem_reg_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_wr(memwb_reg_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
      .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        valid;
      logic [31:0] a, b;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        wr;
      logic [31:0] pc;
      logic        ill;
      bit          chk_data;
      bit          chk_pc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0, n_bad = 0;

   function automatic exp_t mk(string nm, logic v, logic [31:0] a, logic [31:0] b, logic [3:0] c,
                               logic [4:0] rd, logic wr, logic [31:0] pc, logic ill,
                               bit cd, bit cp);
      exp_t e;
      e.name = nm; e.valid = v; e.a = a; e.b = b; e.ctrl = c; e.rd = rd; e.wr = wr;
      e.pc = pc; e.ill = ill; e.chk_data = cd; e.chk_pc = cp;
      return e;
   endfunction

   function automatic exp_t bub(string nm);
      return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
   endfunction

   function automatic exp_t ill(string nm, logic [31:0] pc);
      return mk(nm, 0, 0, 0, 0, 0, 0, pc, 1, 0, 1);
   endfunction

   function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1,
                                        logic [2:0] f3, logic [4:0] d);
      return {f7, s2, s1, f3, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_t(logic [11:0] im, logic [4:0] s1, logic [2:0] f3,
                                        logic [4:0] d);
      return {im, s1, f3, d, 7'b0010011};
   endfunction

   // monitor: one expectation consumed per falling edge
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic bad;
         e = sb.pop_front();
         n_cmp++;
         bad = (ex_valid !== e.valid) || (ex_reg_wr !== e.wr) || (ex_alu_ctrl !== e.ctrl) ||
               (ex_illegal !== e.ill) ||
               (e.chk_data && ((ex_a !== e.a) || (ex_b !== e.b) || (ex_rd !== e.rd))) ||
               (e.chk_pc && (ex_pc !== e.pc));
         if (bad) begin
            n_bad++;
            $display("FAIL %s: got v=%b a=%h b=%h c=%0d rd=%0d wr=%b pc=%h il=%b / want v=%b a=%h b=%h c=%0d rd=%0d wr=%b pc=%h il=%b",
                     e.name, ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_rd, ex_reg_wr, ex_pc, ex_illegal,
                     e.valid, e.a, e.b, e.ctrl, e.rd, e.wr, e.pc, e.ill);
         end
      end
   end

   task automatic drive(logic v, logic [31:0] ins, logic [31:0] pc, logic [31:0] d1, logic [31:0] d2);
      in_valid = v; in_instr = ins; in_pc = pc; rf_rs1_data = d1; rf_rs2_data = d2;
   endtask

   task automatic fwd(logic ew, logic [4:0] erd, logic [31:0] er,
                      logic mw, logic [4:0] mrd, logic [31:0] mr);
      exmem_reg_wr = ew; exmem_rd = erd; exmem_result = er;
      memwb_reg_wr = mw; memwb_rd = mrd; memwb_result = mr;
   endtask

   task automatic tick(exp_t e);
      @(posedge clk);
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   initial begin
      // reset state
      @(posedge clk);
      sb.push_back(mk("reset", 0, 0, 0, 0, 0, 0, RST_PC, 0, 1, 1));
      @(negedge clk); #1;
      rst_n = 1'b1;

      drive(1, r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h10, 32'd5, 32'd7);
      tick(mk("add", 1, 5, 7, 0, 3, 1, 32'h10, 0, 1, 1));
      drive(1, i_t(12'hFFF, 5'd1, 3'b000, 5'd4), 32'h14, 32'd10, 32'd99);
      tick(mk("addi_neg", 1, 10, 32'hFFFF_FFFF, 0, 4, 1, 32'h14, 0, 1, 1));

      drive(1, r_t(7'h20, 5'd7, 5'd5, 3'b000, 5'd6), 32'h18, 32'd1, 32'd2);
      fwd(1, 5'd5, 32'hAA, 1, 5'd5, 32'hBB);
      tick(mk("fwd_exmem_prio", 1, 32'hAA, 2, 1, 6, 1, 32'h18, 0, 1, 1));
      fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
      tick(mk("fwd_rd_mismatch", 1, 1, 2, 1, 6, 1, 32'h18, 0, 1, 1));
      fwd(0, 5'd5, 32'hAA, 1, 5'd5, 32'hBB);
      tick(mk("fwd_memwb_when_exmem_off", 1, 32'hBB, 2, 1, 6, 1, 32'h18, 0, 1, 1));
      drive(1, r_t(7'h20, 5'd7, 5'd0, 3'b000, 5'd6), 32'h1C, 32'd1, 32'd2);
      fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
      tick(mk("x0_not_fwd", 1, 1, 2, 1, 6, 1, 32'h1C, 0, 1, 1));
      drive(1, r_t(7'h00, 5'd10, 5'd9, 3'b110, 5'd8), 32'h20, 32'd1, 32'd2);
      fwd(1, 5'd9, 32'hCC, 1, 5'd10, 32'hBB);
      tick(mk("or_fwd_both", 1, 32'hCC, 32'hBB, 3, 8, 1, 32'h20, 0, 1, 1));
      fwd(0, 5'd0, 0, 0, 5'd0, 0);

      // illegal, then clear on next load
      drive(1, r_t(7'h00, 5'd3, 5'd2, 3'b101, 5'd1), 32'h24, 32'd1, 32'd2);
      tick(ill("srl_illegal", 32'h24));
      drive(1, i_t(12'h7FF, 5'd1, 3'b111, 5'd2), 32'h28, 32'd3, 32'd0);
      tick(mk("andi_clears", 1, 3, 32'h7FF, 2, 2, 1, 32'h28, 0, 1, 1));
      drive(1, r_t(7'h00, 5'd2, 5'd1, 3'b100, 5'd0), 32'h2C, 32'd4, 32'd6);
      tick(mk("xor_rd0", 1, 4, 6, 4, 0, 0, 32'h2C, 0, 1, 1));
      drive(1, i_t(12'h800, 5'd1, 3'b110, 5'd9), 32'h30, 32'd8, 32'd0);
      tick(mk("ori_imm_sext", 1, 8, 32'hFFFF_F800, 3, 9, 1, 32'h30, 0, 1, 1));
      drive(1, r_t(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'h34, 32'd1, 32'd2);
      tick(ill("slt_illegal", 32'h34));
      drive(1, r_t(7'h20, 5'd2, 5'd1, 3'b111, 5'd3), 32'h38, 32'd1, 32'd2);
      tick(ill("and_f7alt_illegal", 32'h38));
      drive(1, {20'h12345, 5'd1, 7'b0110111}, 32'h3C, 32'd1, 32'd2);
      tick(ill("lui_illegal", 32'h3C));
      drive(1, i_t(12'h005, 5'd1, 3'b010, 5'd3), 32'h3E, 32'd1, 32'd2);
      tick(ill("slti_illegal", 32'h3E));
      stall = 1'b1;
      drive(1, i_t(12'h001, 5'd1, 3'b000, 5'd3), 32'h3F, 32'd1, 32'd2);
      tick(ill("stall_holds_illegal", 32'h3E));
      stall = 1'b0;

      // stall hold, then stall+flush bubble
      drive(1, r_t(7'h00, 5'd2, 5'd1, 3'b011, 5'd5), 32'h40, 32'd1, 32'd2);
      tick(mk("sltu", 1, 1, 2, 5, 5, 1, 32'h40, 0, 1, 1));
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, r_t(7'h00, 5'd4, 5'd3, 3'b000, 5'd7), 32'h99 + i, 32'd9 + i, 32'd9);
         tick(mk("stall_hold", 1, 1, 2, 5, 5, 1, 32'h40, 0, 1, 1));
      end
      flush = 1'b1;
      tick(bub("stall_flush_bubble"));
      stall = 1'b0; flush = 1'b0;
      drive(0, r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h44, 32'd1, 32'd2);
      tick(bub("invalid_bubble"));

      // asynchronous reset between edges
      drive(1, r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h48, 32'd5, 32'd7);
      tick(mk("add_pre_reset", 1, 5, 7, 0, 3, 1, 32'h48, 0, 1, 1));
      @(posedge clk); #2;
      rst_n = 1'b0;
      sb.push_back(mk("async_reset", 0, 0, 0, 0, 0, 0, RST_PC, 0, 1, 1));
      @(negedge clk); #1;
      rst_n = 1'b1;
      drive(1, r_t(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 32'h4C, 32'd6, 32'd3);
      tick(mk("first_load_after_reset", 1, 6, 3, 2, 3, 1, 32'h4C, 0, 1, 1));

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/issue stage and ID/EX pipeline register sitting directly upstream of the ALU.
- Decodes RV32I OP and OP-IMM instructions into the ALU's 4-bit control code.
- Selects forwarded or register-file operands and generates the sign-extended immediate.
- Registers everything for the EX stage, with stall, flush and bubble handling.

Parameters:
- XLEN, 32, datapath width (fixed at 32 for the ALU).
- RESET_PC, 32'h0000_0000, reset value of ex_pc.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID holds a valid instruction
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- rf_rs1_data  in  32  register file read of rs1
- rf_rs2_data  in  32  register file read of rs2
- exmem_reg_wr  in  1  EX/MEM stage will write rd
- exmem_rd  in  5  EX/MEM destination
- exmem_result  in  32  EX/MEM ALU result
- memwb_reg_wr  in  1  MEM/WB stage will write rd
- memwb_rd  in  5  MEM/WB destination
- memwb_result  in  32  MEM/WB writeback value
- stall  in  1  hold the ID/EX register
- flush  in  1  insert a bubble
- ex_valid  out  1  EX holds a valid operation
- ex_a  out  32  ALU operand a
- ex_b  out  32  ALU operand b
- ex_alu_ctrl  out  4  ALU control code
- ex_rd  out  5  destination register
- ex_reg_wr  out  1  result is to be written back
- ex_pc  out  32  PC of the EX instruction
- ex_illegal  out  1  one-cycle flag for an unsupported instruction

Behaviour:
- Reset values: all outputs 0, except ex_pc = RESET_PC. The register is a bubble.
- Latency is 1 cycle: inputs sampled on rising edge N appear on the outputs after edge N.
- Per-edge update priority is reset > flush > stall > load.
  - flush: load a bubble (ex_valid=0, ex_reg_wr=0, ex_illegal=0, ex_alu_ctrl=0, ex_a=ex_b=0, ex_rd=0). Flush wins over a simultaneous stall.
  - stall (no flush): every output holds its value, including ex_illegal.
  - load with in_valid=0: load a bubble.
- ALU control codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLTU=5. The ALU compare is unsigned.
- Decode of opcode 0110011 (OP):
  - funct3 000: funct7 0000000 gives ADD; funct7 0100000 gives SUB.
  - funct3 111/110/100/011 with funct7 0000000 give AND/OR/XOR/SLTU.
- Decode of opcode 0010011 (OP-IMM):
  - funct3 000/111/110/100/011 give ADD/AND/OR/XOR/SLTU.
  - funct7 is ignored.
- Everything else is illegal: other opcodes, shifts, SLT, SLTI, and any OP funct7 not listed above.
- On loading an illegal instruction: ex_valid=0, ex_reg_wr=0, ex_alu_ctrl=0, ex_illegal=1, ex_pc=in_pc. On the next non-stalled edge the load clears ex_illegal.
- ex_rd = instr[11:7]. ex_reg_wr = 1 for legal instructions with rd != 0.
  - rd = 0 still gives ex_valid=1, so it counts as an issued NOP.
- Operand a = fwd(rs1).
- Operand b:
  - OP: fwd(rs2).
  - OP-IMM: sign-extended instr[31:20], so bit 31 replicates into [31:12].
- Forwarding fwd(r), combinational before the register:
  - If exmem_reg_wr and exmem_rd == r and r != 0, use exmem_result.
  - Else if memwb_reg_wr and memwb_rd == r and r != 0, use memwb_result.
  - Else use the register-file data.
  - EX/MEM has priority when both stages match.
- Register x0 is never forwarded.
- Load-use and other hazard detection is external and arrives via stall/flush.
- Reset asserted mid-operation clears outputs immediately (asynchronous). The first load occurs on the first rising edge after deassertion.

Decomposition:
- Shared package rv_pkg holds:
  - ALU_ADD..ALU_SLTU codes (4 bits).
  - OPC_OP = 7'b0110011 and OPC_OP_IMM = 7'b0010011.
  - funct3/funct7 constants.
- One sub-module, alu_decoder: purely combinational, maps opcode/funct3/funct7 to alu_ctrl, illegal, use_imm.
- Forwarding muxes and the pipeline register stay in id_ex_stage.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, no forwarding, one edge -> ex_valid=1, ex_a=5, ex_b=7, ex_alu_ctrl=0, ex_rd=3, ex_reg_wr=1.
- ADDI x4,x1,-1 (imm 0xFFF), rs1=10 -> ex_b=32'hFFFF_FFFF, ex_alu_ctrl=0.
- SUB with rs1=x5, exmem_rd=5 (result 0xAA) and memwb_rd=5 (result 0xBB), both write-enabled -> ex_a=0xAA.
  - Same with exmem_rd=0 and memwb_rd=0 -> ex_a=rf data.
- SRL instruction -> ex_illegal=1, ex_valid=0, ex_reg_wr=0.
  - Next cycle a valid ANDI -> ex_illegal=0, ex_alu_ctrl=2.
- Load SLTU, then stall for 3 cycles with changing inputs -> outputs unchanged.
  - stall and flush together -> bubble.
- Assert rst_n=0 between clock edges while ex_valid=1 -> outputs zero immediately, ex_pc=RESET_PC.
